// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder.
// State encoding, latched request bundle and byte-lane helper.
package dmem_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dmem_req_t;

  function automatic logic [31:0] be_mask(
    input logic [WORD_BYTES-1:0] be
  );
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-enabled word storage: combinational read,
// synchronous write on one shared address port.
module dmem_array #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);
  import dmem_pkg::*;

  logic [31:0] mem_q [DEPTH];

  // Contents survive reset by design.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (be[i]) begin
          mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with programmable wait states.
// One outstanding request; single-cycle response pulse.
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  import dmem_pkg::*;

  localparam int AW = $clog2(DEPTH);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  dmem_req_t   req_q, req_d;
  logic        err;
  logic        mem_we;
  logic [31:0] mem_rdata;

  assign req_ready = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d.we    = req_we;
          req_d.addr  = req_addr;
          req_d.wdata = req_wdata;
          req_d.be    = req_be;
          cnt_d       = 4'(LATENCY - 1);
          state_d     = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  assign err = (req_q.addr[1:0] != 2'b00)
            || (req_q.addr[31:2] >= 30'(DEPTH));

  // Gating with reset drops a write caught in RESP by reset.
  assign mem_we = (state_q == RESP) && req_q.we
               && !err && reset;

  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid && err;
  assign resp_rdata = (resp_valid && !req_q.we && !err)
                    ? (mem_rdata & be_mask(req_q.be))
                    : '0;

  dmem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .be   (req_q.be),
    .addr (req_q.addr[AW+1:2]),
    .wdata(req_q.wdata),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder at LATENCY 2, 1 and 4.
// Vector table, random traffic against a word-array model.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int NI    = 3;

  logic        clk;
  logic        rst_n      [NI];
  logic        req_valid  [NI];
  logic        req_ready  [NI];
  logic        req_we     [NI];
  logic [31:0] req_addr   [NI];
  logic [31:0] req_wdata  [NI];
  logic [3:0]  req_be     [NI];
  logic        resp_valid [NI];
  logic [31:0] resp_rdata [NI];
  logic        resp_err   [NI];

  int tests;
  int fails;

  logic [31:0] model [NI][DEPTH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_responder #(
      .DEPTH  (DEPTH),
      .LATENCY((g == 0) ? 2 : (g == 1) ? 1 : 4)
    ) u_dut (
      .clk       (clk),
      .reset     (rst_n[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_be    (req_be[g]),
      .resp_valid(resp_valid[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g])
    );
  end

  function automatic int lat(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 4;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  // Reference: memory as a plain word array, bytes by shifting.
  task automatic model_op(input int k,
                          input logic we,
                          input logic [31:0] addr,
                          input logic [31:0] wd,
                          input logic [3:0] be,
                          output logic [31:0] rd,
                          output logic e);
    int unsigned w;
    logic [31:0] word;
    rd = 0;
    e  = ((addr % 4) != 0) || ((addr / 4) >= DEPTH);
    if (!e) begin
      w = addr / 4;
      word = model[k][w];
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          if (we) begin
            word = (word & ~(32'hFF << (8*b)))
                 | (wd & (32'hFF << (8*b)));
          end else begin
            rd = rd | (word & (32'hFF << (8*b)));
          end
        end
      end
      model[k][w] = word;
    end
  endtask

  task automatic xact_exp(input int k,
                          input logic we,
                          input logic [31:0] addr,
                          input logic [31:0] wd,
                          input logic [3:0] be,
                          input logic [31:0] exp_rd,
                          input logic exp_err,
                          input string tag);
    bit got;
    @(negedge clk);
    chk({tag, " ready_idle"}, 32'(req_ready[k]), 1);
    chk({tag, " valid_idle"}, 32'(resp_valid[k]), 0);
    chk({tag, " rdata_idle"}, resp_rdata[k], 0);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wd;
    req_be[k]    = be;
    @(posedge clk);
    #1 req_valid[k] = 1'b0;
    got = 0;
    for (int n = 1; n <= lat(k) + 4 && !got; n++) begin
      @(negedge clk);
      chk({tag, " ready_busy"}, 32'(req_ready[k]), 0);
      if (resp_valid[k]) begin
        got = 1;
        chk({tag, " latency"}, 32'(n), 32'(lat(k)));
        chk({tag, " rdata"}, resp_rdata[k], exp_rd);
        chk({tag, " err"}, 32'(resp_err[k]), 32'(exp_err));
      end
    end
    if (!got) chk({tag, " timeout"}, 0, 1);
  endtask

  task automatic xact(input int k,
                      input logic we,
                      input logic [31:0] addr,
                      input logic [31:0] wd,
                      input logic [3:0] be,
                      input string tag);
    logic [31:0] rd;
    logic e;
    model_op(k, we, addr, wd, be, rd, e);
    xact_exp(k, we, addr, wd, be, rd, e, tag);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    int unsigned r;
    r = $urandom_range(0, 9);
    a = 32'($urandom_range(0, DEPTH - 1)) << 2;
    if (r == 0) a = a | 32'($urandom_range(1, 3));
    if (r == 1) a = a + 32'(DEPTH * 4) + ($urandom << 8);
    return a;
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vt [16];

  logic [31:0] s_addr  [40];
  logic [31:0] s_wdata [40];
  logic [3:0]  s_be    [40];
  logic        s_we    [40];
  logic [31:0] q_rd    [$];
  logic        q_err   [$];

  initial begin
    logic [31:0] rd;
    logic        e;
    int          idx;
    int          nresp;
    int          last;
    bit          r;
    tests = 0;
    fails = 0;

    vt[0]  = '{1'b1, 32'h00, 32'h12345678, 4'hF, 32'h0, 1'b0};
    vt[1]  = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
    vt[2]  = '{1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0};
    vt[3]  = '{1'b1, 32'h10, 32'h000000AA, 4'h1, 32'h0, 1'b0};
    vt[4]  = '{1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEAA, 1'b0};
    vt[5]  = '{1'b0, 32'h10, 32'h0, 4'hC, 32'hDEAD0000, 1'b0};
    vt[6]  = '{1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0};
    vt[7]  = '{1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0};
    vt[8]  = '{1'b0, 32'h10, 32'h0, 4'h3, 32'h0000BEAA, 1'b0};
    vt[9]  = '{1'b0, 32'h12, 32'h0, 4'hF, 32'h0, 1'b1};
    vt[10] = '{1'b1, 32'h100, 32'h11111111, 4'hF, 32'h0, 1'b1};
    vt[11] = '{1'b0, 32'h00, 32'h0, 4'hF, 32'h12345678, 1'b0};
    vt[12] = '{1'b1, 32'hFC, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0};
    vt[13] = '{1'b0, 32'hFC, 32'h0, 4'h6, 32'h00A5A500, 1'b0};
    vt[14] = '{1'b0, 32'hFFFFFFF0, 32'h0, 4'hF, 32'h0, 1'b1};
    vt[15] = '{1'b0, 32'h101, 32'h0, 4'hF, 32'h0, 1'b1};

    // Reset with a write pending on every instance.
    for (int k = 0; k < NI; k++) begin
      rst_n[k]     = 1'b0;
      req_valid[k] = 1'b1;
      req_we[k]    = 1'b1;
      req_addr[k]  = 32'h40;
      req_wdata[k] = 32'h5A5A5A5A;
      req_be[k]    = 4'hF;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      req_valid[k] = 1'b0;
      rst_n[k]     = 1'b1;
    end
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("rst ready", 32'(req_ready[k]), 1);
      chk("rst valid", 32'(resp_valid[k]), 0);
      chk("rst rdata", resp_rdata[k], 0);
      chk("rst err", 32'(resp_err[k]), 0);
    end

    for (int k = 0; k < NI; k++) begin
      for (int w = 0; w < DEPTH; w++) begin
        xact(k, 1'b1, 32'(w * 4), $urandom, 4'hF, "init");
      end
    end

    for (int i = 0; i < 16; i++) begin
      model_op(0, vt[i].we, vt[i].addr, vt[i].wdata,
               vt[i].be, rd, e);
      xact_exp(0, vt[i].we, vt[i].addr, vt[i].wdata,
               vt[i].be, vt[i].exp_rd, vt[i].exp_err,
               $sformatf("vec%0d", i));
    end

    // A write held through reset must not land.
    @(negedge clk);
    rst_n[0]     = 1'b0;
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'h10;
    req_wdata[0] = 32'h0;
    req_be[0]    = 4'hF;
    repeat (2) @(negedge clk);
    chk("rst2 valid", 32'(resp_valid[0]), 0);
    req_valid[0] = 1'b0;
    rst_n[0]     = 1'b1;
    xact_exp(0, 1'b0, 32'h10, 0, 4'hF,
             32'hDEADBEAA, 1'b0, "rst2 read");

    for (int i = 0; i < 25; i++) begin
      xact(0, 1'($urandom), rand_addr(), $urandom,
           4'($urandom), "rand0");
    end

    // LATENCY=1 stream with req_valid held high.
    for (int i = 0; i < 40; i++) begin
      s_we[i]    = 1'(i % 2 == 0);
      s_addr[i]  = (i % 7 == 6) ? rand_addr()
                 : 32'($urandom_range(0, 7)) << 2;
      s_wdata[i] = $urandom;
      s_be[i]    = 4'($urandom);
    end
    idx   = 0;
    nresp = 0;
    last  = -1;
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_we[1]    = s_we[0];
    req_addr[1]  = s_addr[0];
    req_wdata[1] = s_wdata[0];
    req_be[1]    = s_be[0];
    for (int cyc = 0; cyc < 200 && nresp < 40; cyc++) begin
      r = req_ready[1];
      if (resp_valid[1]) begin
        if (q_rd.size() == 0) begin
          chk("stream extra", 32'(resp_valid[1]), 0);
        end else begin
          chk("stream rdata", resp_rdata[1], q_rd.pop_front());
          chk("stream err", 32'(resp_err[1]),
              32'(q_err.pop_front()));
        end
        if (last >= 0) chk("stream gap", 32'(cyc - last), 2);
        last = cyc;
        nresp++;
      end else begin
        chk("stream idle rdata", resp_rdata[1], 0);
      end
      @(posedge clk);
      if (r && idx < 40) begin
        model_op(1, s_we[idx], s_addr[idx], s_wdata[idx],
                 s_be[idx], rd, e);
        q_rd.push_back(rd);
        q_err.push_back(e);
        idx++;
      end
      #1;
      if (idx < 40) begin
        req_we[1]    = s_we[idx];
        req_addr[1]  = s_addr[idx];
        req_wdata[1] = s_wdata[idx];
        req_be[1]    = s_be[idx];
      end else begin
        req_valid[1] = 1'b0;
      end
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    chk("stream count", 32'(nresp), 40);
    chk("stream left", 32'(q_rd.size()), 0);

    // LATENCY=4: reset while waiting discards the write.
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b1;
    req_addr[2]  = 32'h20;
    req_wdata[2] = 32'hCAFEF00D;
    req_be[2]    = 4'hF;
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    @(negedge clk);
    chk("midrst busy", 32'(req_ready[2]), 0);
    rst_n[2] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("midrst valid", 32'(resp_valid[2]), 0);
    end
    rst_n[2] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("midrst after", 32'(resp_valid[2]), 0);
    end
    chk("midrst ready", 32'(req_ready[2]), 1);
    xact(2, 1'b0, 32'h20, 0, 4'hF, "midrst read");

    for (int i = 0; i < 20; i++) begin
      xact(2, 1'($urandom), rand_addr(), $urandom,
           4'($urandom), "rand2");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
